crossing_gate_actuator: RTL and testbench
=========================================

// Module: crossing_gate_actuator
// PURPOSE
//   Responder end of the crossing controller's gate command. Turns the level gate_cmd (1 = close)
//   into barrier motor drive, warning lamp/bell, and gate status. Watches the up/down limit
//   switches and flags travel faults. Sits between the crossing FSM and the barrier mechanics.
// PARAMETERS
//   PREWARN_CYCLES  8   cycles of lamp+bell warning before the barrier starts lowering
//   TRAVEL_TIMEOUT  32  max cycles a motor runs before the limit switch must assert
//   FLASH_HALF      4   lamp half-period in cycles (on FLASH_HALF, then off FLASH_HALF)
// PORTS
//   clk        in   1  single system clock; all logic on the rising edge
//   rst_n      in   1  synchronous reset, active-low
//   gate_cmd   in   1  1 = close barrier, 0 = open barrier (level, from the crossing FSM)
//   lim_up     in   1  barrier fully-up limit switch
//   lim_down   in   1  barrier fully-down limit switch
//   motor_dn   out  1  drive barrier down
//   motor_up   out  1  drive barrier up
//   lamp       out  1  warning lamp (flashing while active)
//   bell       out  1  warning bell
//   gate_down  out  1  barrier confirmed down
//   gate_up    out  1  barrier confirmed up
//   fault      out  1  sticky travel or sensor fault
// BEHAVIOUR
//   - Outputs are Moore outputs decoded from the registered state. No output depends on inputs.
//   - States: UP, PREWARN, LOWERING, DOWN, RAISING, FAULT. Reset state is UP.
//   - Reset (rst_n=0 at a clock edge): state=UP, timer=0, flash phase=0, retry=0.
//     Every output is 0 except gate_up, which follows lim_up.
//   - Timer clears on every state change and counts while in PREWARN, LOWERING or RAISING.
//     Width is $clog2(max(PREWARN_CYCLES,TRAVEL_TIMEOUT)+1). Saturates and never wraps.
//   - UP: gate_up = lim_up.
//       gate_cmd=1 -> PREWARN.
//       Else if !lim_up -> RAISING (homing after reset or drift).
//   - PREWARN: lamp flashes, bell=1, motors off.
//       gate_cmd=0 -> UP (abort).
//       Else when timer==PREWARN_CYCLES-1 -> LOWERING.
//   - LOWERING: motor_dn=1, lamp flashes, bell=1.
//       lim_down -> DOWN.
//       Else when timer==TRAVEL_TIMEOUT-1 -> FAULT.
//       A gate_cmd drop is ignored: travel completes, then DOWN sees cmd=0 and raises.
//   - DOWN: gate_down=1, lamp flashes, bell=0.
//       gate_cmd=0 -> RAISING.
//   - RAISING: motor_up=1, lamp flashes.
//       gate_cmd=1 -> LOWERING immediately (safety reversal, no prewarn; timer cleared).
//       Else lim_up -> UP.
//       Else when timer==TRAVEL_TIMEOUT-1 -> FAULT.
//   - FAULT: motors off, lamp steady 1, bell=1, fault=1. Exit only by reset.
//   - lim_up && lim_down in the same cycle, in any state -> FAULT next cycle.
//     This has priority over all other transitions.
//   - motor_dn && motor_up are never both 1 (guaranteed by state decode).
//   - Flasher: phase counter resets on entry to PREWARN. lamp=1 on the first PREWARN cycle.
//     The phase runs continuously through LOWERING/DOWN/RAISING with no restart.
// CONFIGURATION
//   GATE_AUTO_RETRY_EN defined:
//     The first travel timeout in LOWERING/RAISING does not fault. It restarts the same
//     travel once (timer cleared, 1-cycle motor-off gap) and sets retry.
//     A second timeout -> FAULT. retry clears on reaching DOWN or UP.
//   GATE_AUTO_RETRY_EN undefined:
//     The first timeout -> FAULT. No retry register exists.
// STRUCTURE
//   gate_pkg: state enum (gate_state_t), encodings, default parameter constants.
//   Sub-module gate_lamp_flasher (enable, restart, FLASH_HALF -> lamp). Instantiated once.
// TESTING
//   1 Normal close: gate_cmd 0->1, lim_down at 5th LOWERING cycle -> bell 8 cycles, motor_dn 5,
//     gate_down=1.
//   2 Abort in prewarn: gate_cmd 1 for 3 cycles then 0 -> back to UP, motor_dn never asserted.
//   3 Reversal: gate_cmd=1 mid-RAISING -> next cycle motor_up=0, motor_dn=1, no PREWARN.
//   4 Timeout: lim_down never asserts -> fault=1 after 32 LOWERING cycles (64+gap with
//     GATE_AUTO_RETRY_EN), stays until rst_n=0.
//   5 Sensor conflict: lim_up=lim_down=1 while DOWN -> FAULT next cycle, motors 0, lamp steady 1.
//   6 Reset mid-LOWERING: rst_n=0 one cycle -> all outputs 0. lim_up=0 -> RAISING on next cycle.

Source files
------------

// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gate_pkg
//  Description : Shared types and default constants for the level-crossing
//                barrier actuator: FSM state encoding, default timing
//                parameters and a small constant-evaluation helper.
//  Revision    : 1.0  initial release
// ============================================================================
package gate_pkg;

    // Barrier actuator states. Explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_UP       = 3'd0,
        ST_PREWARN  = 3'd1,
        ST_LOWERING = 3'd2,
        ST_DOWN     = 3'd3,
        ST_RAISING  = 3'd4,
        ST_FAULT    = 3'd5
    } gate_state_t;

    localparam int unsigned DEF_PREWARN_CYCLES = 8;
    localparam int unsigned DEF_TRAVEL_TIMEOUT = 32;
    localparam int unsigned DEF_FLASH_HALF     = 4;

    // Larger of two values, used to size the shared state timer.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_lamp_flasher.sv
`default_nettype none
// ============================================================================
//  Module      : gate_lamp_flasher
//  Description : Warning-lamp flash generator. A phase counter runs over
//                2*FLASH_HALF cycles while enabled; the lamp is lit for the
//                first FLASH_HALF of them. restart_i forces phase 0 so the
//                cycle after a restart is a lit cycle.
//  Ports       : clk        system clock
//                rst_n      synchronous active-low reset
//                enable_i   flashing active (phase advances, lamp may light)
//                restart_i  load phase 0 on the next edge (priority over enable)
//                lamp_o     lamp drive
//  Revision    : 1.0  initial release
// ============================================================================
module gate_lamp_flasher #(
    parameter int unsigned FLASH_HALF = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic restart_i,
    output logic lamp_o
);

    localparam int PH_W = (FLASH_HALF > 1) ? $clog2(2 * FLASH_HALF) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * FLASH_HALF - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(FLASH_HALF);

    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_d;

    always_comb begin
        phase_d = phase_q;
        if (restart_i) begin
            phase_d = '0;
        end else if (enable_i) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign lamp_o = enable_i && (phase_q < PH_HALF);

endmodule
`default_nettype wire

// File: rtl/crossing_gate_actuator.sv
`default_nettype none
// ============================================================================
//  Module      : crossing_gate_actuator
//  Description : Barrier actuator for a level crossing. Converts the level
//                close command into prewarning, motor drive, lamp/bell and
//                gate status, supervises the limit switches and latches
//                travel or sensor faults until reset.
//  Config      : GATE_AUTO_RETRY_EN - when defined, the first travel timeout
//                restarts the same travel once after a one-cycle motor-off
//                gap; a second timeout faults.
//  Ports       : clk          system clock
//                rst_n        synchronous active-low reset
//                gate_cmd_i   1 = close, 0 = open (level)
//                lim_up_i     barrier fully-up switch
//                lim_down_i   barrier fully-down switch
//                motor_dn_o   drive barrier down
//                motor_up_o   drive barrier up
//                lamp_o       warning lamp
//                bell_o       warning bell
//                gate_down_o  barrier confirmed down
//                gate_up_o    barrier confirmed up
//                fault_o      sticky fault
//  Revision    : 1.0  initial release
// ============================================================================
module crossing_gate_actuator
    import gate_pkg::*;
#(
    parameter int unsigned PREWARN_CYCLES = DEF_PREWARN_CYCLES,
    parameter int unsigned TRAVEL_TIMEOUT = DEF_TRAVEL_TIMEOUT,
    parameter int unsigned FLASH_HALF     = DEF_FLASH_HALF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic gate_cmd_i,
    input  logic lim_up_i,
    input  logic lim_down_i,
    output logic motor_dn_o,
    output logic motor_up_o,
    output logic lamp_o,
    output logic bell_o,
    output logic gate_down_o,
    output logic gate_up_o,
    output logic fault_o
);

    localparam int TMR_W = $clog2(max_u(PREWARN_CYCLES, TRAVEL_TIMEOUT) + 1);
    localparam logic [TMR_W-1:0] PW_LAST = TMR_W'(PREWARN_CYCLES - 1);
    localparam logic [TMR_W-1:0] TT_LAST = TMR_W'(TRAVEL_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX = '1;

    gate_state_t      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             travel_to;
    logic             timer_run;
    logic             motor_en;
    logic             flash_en;
    logic             flash_restart;
    logic             flash_lamp;

`ifdef GATE_AUTO_RETRY_EN
    logic retry_q, retry_d;
    // gap_q marks the single motor-off cycle between a timed-out travel and its retry.
    logic gap_q, gap_d;
    assign motor_en = !gap_q;
`else
    assign motor_en = 1'b1;
`endif

    // The timer is held at zero through the retry gap so the retried travel
    // gets the full timeout window.
    assign timer_run = ((state_q == ST_PREWARN) || (state_q == ST_LOWERING) ||
                        (state_q == ST_RAISING)) && motor_en;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        travel_to = 1'b0;
`ifdef GATE_AUTO_RETRY_EN
        retry_d   = retry_q;
        gap_d     = 1'b0;
`endif
        if (timer_run && (timer_q != TMR_MAX)) begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            ST_UP: begin
                if (gate_cmd_i)     state_d = ST_PREWARN;
                else if (!lim_up_i) state_d = ST_RAISING;
            end
            ST_PREWARN: begin
                if (!gate_cmd_i)            state_d = ST_UP;
                else if (timer_q == PW_LAST) state_d = ST_LOWERING;
            end
            ST_LOWERING: begin
                // A dropped command is ignored here; DOWN will raise afterwards.
                if (lim_down_i)              state_d = ST_DOWN;
                else if (timer_q == TT_LAST) travel_to = 1'b1;
            end
            ST_DOWN: begin
                if (!gate_cmd_i) state_d = ST_RAISING;
            end
            ST_RAISING: begin
                // Safety reversal straight back to lowering, no prewarn.
                if (gate_cmd_i)              state_d = ST_LOWERING;
                else if (lim_up_i)           state_d = ST_UP;
                else if (timer_q == TT_LAST) travel_to = 1'b1;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase

        if (travel_to) begin
`ifdef GATE_AUTO_RETRY_EN
            if (retry_q) begin
                state_d = ST_FAULT;
            end else begin
                retry_d = 1'b1;
                gap_d   = 1'b1;
                timer_d = '0;
            end
`else
            state_d = ST_FAULT;
`endif
        end

        // Both limit switches at once is physically impossible: treat as a
        // sensor fault ahead of every other transition.
        if (lim_up_i && lim_down_i) begin
            state_d = ST_FAULT;
        end

        if (state_d != state_q) begin
            timer_d = '0;
`ifdef GATE_AUTO_RETRY_EN
            gap_d   = 1'b0;
`endif
        end

`ifdef GATE_AUTO_RETRY_EN
        if ((state_d == ST_DOWN) || (state_d == ST_UP)) begin
            retry_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_UP;
            timer_q <= '0;
`ifdef GATE_AUTO_RETRY_EN
            retry_q <= 1'b0;
            gap_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
`ifdef GATE_AUTO_RETRY_EN
            retry_q <= retry_d;
            gap_q   <= gap_d;
`endif
        end
    end

    // Flash phase restarts on every entry to PREWARN and otherwise runs
    // uninterrupted through the travel and down states.
    assign flash_restart = (state_d == ST_PREWARN) && (state_q != ST_PREWARN);
    assign flash_en      = (state_q == ST_PREWARN) || (state_q == ST_LOWERING) ||
                           (state_q == ST_DOWN)    || (state_q == ST_RAISING);

    gate_lamp_flasher #(
        .FLASH_HALF (FLASH_HALF)
    ) u_flasher (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_i  (flash_en),
        .restart_i (flash_restart),
        .lamp_o    (flash_lamp)
    );

    // Motor outputs come from mutually exclusive states, so both can never be 1.
    assign motor_dn_o  = (state_q == ST_LOWERING) && motor_en;
    assign motor_up_o  = (state_q == ST_RAISING)  && motor_en;
    assign lamp_o      = (state_q == ST_FAULT) || flash_lamp;
    assign bell_o      = (state_q == ST_PREWARN) || (state_q == ST_LOWERING) ||
                         (state_q == ST_FAULT);
    assign gate_down_o = (state_q == ST_DOWN);
    assign gate_up_o   = (state_q == ST_UP) && lim_up_i;
    assign fault_o     = (state_q == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_crossing_gate_actuator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crossing_gate_actuator
//  Description : Directed self-checking bench for crossing_gate_actuator.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_crossing_gate_actuator;

    logic clk = 1'b0;
    logic rst_n;
    logic gate_cmd;
    logic lim_up;
    logic lim_down;
    logic motor_dn, motor_up, lamp, bell, gate_down, gate_up, fault;

    int n_vec  = 0;
    int n_miss = 0;

    crossing_gate_actuator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gate_cmd_i  (gate_cmd),
        .lim_up_i    (lim_up),
        .lim_down_i  (lim_down),
        .motor_dn_o  (motor_dn),
        .motor_up_o  (motor_up),
        .lamp_o      (lamp),
        .bell_o      (bell),
        .gate_down_o (gate_down),
        .gate_up_o   (gate_up),
        .fault_o     (fault)
    );

    always #5 clk = ~clk;

    // {motor_dn, motor_up, lamp, bell, gate_down, gate_up, fault}
    wire [6:0] outs = {motor_dn, motor_up, lamp, bell, gate_down, gate_up, fault};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: UP -> PREWARN(8) -> LOWERING(2) -> DOWN.
    task automatic drive_to_down();
        gate_cmd = 1'b1;
        repeat (9) tick();
        lim_up = 1'b0;
        tick();
        lim_down = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; gate_cmd = 1'b0; lim_up = 1'b1; lim_down = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; gate_cmd = 1'b0; lim_up = 1'b1; lim_down = 1'b0;
        tick(); tick();
        n_vec++;
        if (outs !== 7'b0000010) begin
            n_miss++; $display("FAIL reset_outs: got %b expected %b", outs, 7'b0000010);
        end
        lim_up = 1'b0;
        #1;
        n_vec++;
        if (gate_up !== 1'b0) begin
            n_miss++; $display("FAIL reset_gate_up_follows: got %b expected 0", gate_up);
        end
        lim_up = 1'b1;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        n_vec++;
        if (outs !== 7'b0000010) begin
            n_miss++; $display("FAIL idle_up: got %b expected %b", outs, 7'b0000010);
        end
    endtask

    task automatic test_normal_close();
        int pre = 0;
        int mov = 0;
        int idx = 0;
        int guard = 0;
        logic both = 1'b0;
        logic [12:0] lh = '0;
        gate_cmd = 1'b1;
        while (guard < 40) begin
            tick();
            guard++;
            if (motor_dn && motor_up) both = 1'b1;
            if (gate_down) break;
            if (bell && !motor_dn) pre++;
            if (motor_dn) begin mov++; lim_up = 1'b0; end
            if (idx < 13) lh[idx] = lamp;
            idx++;
            if (mov == 5) lim_down = 1'b1;
        end
        n_vec++;
        if (pre !== 8) begin
            n_miss++; $display("FAIL close_prewarn_cycles: got %0d expected 8", pre);
        end
        n_vec++;
        if (mov !== 5) begin
            n_miss++; $display("FAIL close_motor_dn_cycles: got %0d expected 5", mov);
        end
        n_vec++;
        if (lh !== 13'b0111100001111) begin
            n_miss++; $display("FAIL close_lamp_pattern: got %b expected %b", lh, 13'b0111100001111);
        end
        n_vec++;
        if (both !== 1'b0) begin
            n_miss++; $display("FAIL close_motor_exclusive: got %b expected 0", both);
        end
        // DOWN entered at flash phase 5: lamp off, bell off, motors off.
        n_vec++;
        if (outs !== 7'b0000100) begin
            n_miss++; $display("FAIL close_down_outs: got %b expected %b", outs, 7'b0000100);
        end
        repeat (3) tick();
        n_vec++;
        if (lamp !== 1'b1) begin
            n_miss++; $display("FAIL down_lamp_flashing: got %b expected 1", lamp);
        end
    endtask

    task automatic test_reversal();
        gate_cmd = 1'b0;
        tick();
        lim_down = 1'b0;
        n_vec++;
        if ({motor_dn, motor_up} !== 2'b01) begin
            n_miss++; $display("FAIL raise_start: got %b expected 01", {motor_dn, motor_up});
        end
        tick(); tick();
        gate_cmd = 1'b1;
        tick();
        n_vec++;
        if ({motor_dn, motor_up, bell} !== 3'b101) begin
            n_miss++; $display("FAIL reversal: got %b expected 101", {motor_dn, motor_up, bell});
        end
        lim_down = 1'b1;
        tick();
        n_vec++;
        if (gate_down !== 1'b1) begin
            n_miss++; $display("FAIL reversal_down: got %b expected 1", gate_down);
        end
        gate_cmd = 1'b0;
        tick();
        lim_down = 1'b0;
        tick();
        lim_up = 1'b1;
        tick();
        n_vec++;
        if (outs !== 7'b0000010) begin
            n_miss++; $display("FAIL raise_to_up: got %b expected %b", outs, 7'b0000010);
        end
    endtask

    task automatic test_abort();
        logic seen = 1'b0;
        gate_cmd = 1'b1;
        repeat (3) begin
            tick();
            if (motor_dn) seen = 1'b1;
        end
        n_vec++;
        if ({bell, motor_dn, gate_up} !== 3'b100) begin
            n_miss++; $display("FAIL abort_prewarn: got %b expected 100", {bell, motor_dn, gate_up});
        end
        gate_cmd = 1'b0;
        tick();
        n_vec++;
        if (outs !== 7'b0000010) begin
            n_miss++; $display("FAIL abort_to_up: got %b expected %b", outs, 7'b0000010);
        end
        repeat (10) begin
            tick();
            if (motor_dn) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_miss++; $display("FAIL abort_no_motor: got %b expected 0", seen);
        end
    endtask

    task automatic test_timeout();
        int mov = 0;
        int cyc = 0;
        int exp_mov;
`ifdef GATE_AUTO_RETRY_EN
        exp_mov = 64;
`else
        exp_mov = 32;
`endif
        gate_cmd = 1'b1;
        while (!fault && cyc < 300) begin
            tick();
            cyc++;
            if (motor_dn) begin mov++; lim_up = 1'b0; end
        end
        n_vec++;
        if (fault !== 1'b1) begin
            n_miss++; $display("FAIL timeout_fault: got %b expected 1 (timed out after %0d cycles)", fault, cyc);
        end
        n_vec++;
        if (mov !== exp_mov) begin
            n_miss++; $display("FAIL timeout_motor_cycles: got %0d expected %0d", mov, exp_mov);
        end
        n_vec++;
        if (outs !== 7'b0011001) begin
            n_miss++; $display("FAIL fault_outs: got %b expected %b", outs, 7'b0011001);
        end
        gate_cmd = 1'b0;
        lim_up = 1'b1;
        repeat (20) tick();
        n_vec++;
        if (fault !== 1'b1) begin
            n_miss++; $display("FAIL fault_sticky: got %b expected 1", fault);
        end
        do_reset();
        n_vec++;
        if (outs !== 7'b0000010) begin
            n_miss++; $display("FAIL fault_cleared_by_reset: got %b expected %b", outs, 7'b0000010);
        end
    endtask

    task automatic test_sensor_conflict();
        drive_to_down();
        n_vec++;
        if (gate_down !== 1'b1) begin
            n_miss++; $display("FAIL conflict_setup_down: got %b expected 1", gate_down);
        end
        lim_up = 1'b1;
        tick();
        n_vec++;
        if (outs !== 7'b0011001) begin
            n_miss++; $display("FAIL conflict_fault: got %b expected %b", outs, 7'b0011001);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_lowering();
        gate_cmd = 1'b1;
        repeat (9) tick();
        lim_up = 1'b0;
        tick();
        n_vec++;
        if (motor_dn !== 1'b1) begin
            n_miss++; $display("FAIL midlower_setup: got %b expected 1", motor_dn);
        end
        rst_n = 1'b0;
        gate_cmd = 1'b0;
        tick();
        n_vec++;
        if (outs !== 7'b0000000) begin
            n_miss++; $display("FAIL midlower_reset_outs: got %b expected %b", outs, 7'b0000000);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (outs !== 7'b0110000) begin
            n_miss++; $display("FAIL homing_raise: got %b expected %b", outs, 7'b0110000);
        end
        lim_up = 1'b1;
        tick();
        n_vec++;
        if (outs !== 7'b0000010) begin
            n_miss++; $display("FAIL homing_up: got %b expected %b", outs, 7'b0000010);
        end
    endtask

    initial begin
        rst_n = 1'b0; gate_cmd = 1'b0; lim_up = 1'b1; lim_down = 1'b0;
        test_reset();
        test_normal_close();
        test_reversal();
        test_abort();
        test_timeout();
        test_sensor_conflict();
        test_reset_mid_lowering();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
